// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: reset/trap vectors, the NOP encoding and
// the IF/ID pipeline register layout used by the fetch stage.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC_DEF  = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h8000_0008;
    localparam logic [31:0] NOP          = 32'h0000_0000;
    localparam logic [31:0] SUPERVISOR   = 32'h8000_0000;

    // Next-PC source, listed from lowest to highest priority.
    typedef enum logic [2:0] {
        PC_SEQ,
        PC_HOLD,
        PC_BR,
        PC_JUMP,
        PC_JR,
        PC_IRQ,
        PC_EXC
    } pc_sel_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    // Trap vectors always enter in supervisor mode (PC bit 31 set).
    function automatic logic [31:0] vector_pc(input logic [31:0] vec);
        return vec | SUPERVISOR;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory bus: the fetch stage presents an address and receives
// the addressed word combinationally in the same cycle.
interface instruction_fetch_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_data;

    modport master (output imem_addr, input imem_data);
    modport slave  (input imem_addr, output imem_data);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: a bubble beats a hold, a hold beats a load.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic [31:0] pc_plus4,
    input  logic        en,
    input  logic        bubble,
    output if_id_t      q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (bubble) begin
            q <= '{inst: NOP, pc_plus4: pc_plus4, valid: 1'b0};
        end else if (en) begin
            q <= '{inst: inst, pc_plus4: pc_plus4, valid: 1'b1};
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register with prioritised redirect mux, edge-triggered
// single-slot interrupt request, and the IF/ID register.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] IRQ_VEC  = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       br_taken,
    input  logic [31:0]                br_target,
    input  logic                       jump,
    input  logic [31:0]                jump_target,
    input  logic                       jr,
    input  logic [31:0]                jr_target,
    input  logic                       exception,
    input  logic                       irq,
    instruction_fetch_if.master        imem,
    output logic [31:0]                if_id_inst,
    output logic [31:0]                if_id_pc_plus4,
    output logic                       if_id_valid,
    output logic                       irq_ack,
    output logic [31:0]                irq_epc
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    pc_sel_e     pc_sel;
    logic        irq_prev;
    logic        irq_pending;
    logic        irq_take;
    if_id_t      if_id_q;

    assign imem.imem_addr = pc;
    assign pc_plus4       = pc + 32'd4;

    // Interrupts are only taken from user mode on an otherwise quiet cycle.
    assign irq_take = irq_pending && !pc[31] && !exception && !jr && !jump
                      && !br_taken && !stall;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_sel = PC_SEQ;
        if (exception)     pc_sel = PC_EXC;
        else if (irq_take) pc_sel = PC_IRQ;
        else if (jr)       pc_sel = PC_JR;
        else if (jump)     pc_sel = PC_JUMP;
        else if (br_taken) pc_sel = PC_BR;
        else if (stall)    pc_sel = PC_HOLD;
    end

    always_comb begin
        next_pc = pc_plus4;
        case (pc_sel)
            PC_EXC:  next_pc = vector_pc(EXC_VEC);
            PC_IRQ:  next_pc = vector_pc(IRQ_VEC);
            PC_JR:   next_pc = jr_target;
            PC_JUMP: next_pc = jump_target;
            PC_BR:   next_pc = br_target;
            PC_HOLD: next_pc = pc;
            default: next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= RESET_PC;
        else        pc <= next_pc;
    end

    // A second edge while a request is already pending is absorbed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev    <= 1'b0;
            irq_pending <= 1'b0;
            irq_ack     <= 1'b0;
            irq_epc     <= 32'h0;
        end else begin
            irq_prev <= irq;
            irq_ack  <= irq_take;
            if (irq_take) begin
                irq_epc     <= pc;
                irq_pending <= 1'b0;
            end else if (irq && !irq_prev) begin
                irq_pending <= 1'b1;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .inst     (imem.imem_data),
        .pc_plus4 (pc_plus4),
        .en       (!stall),
        .bubble   (flush || exception || irq_take),
        .q        (if_id_q)
    );

    assign if_id_inst     = if_id_q.inst;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign if_id_valid    = if_id_q.valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the fetch stage.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, flush, br_taken, jump, jr, exception, irq;
    logic [31:0] br_target, jump_target, jr_target;
    logic [31:0] if_id_inst, if_id_pc_plus4, irq_epc;
    logic        if_id_valid, irq_ack;
    logic [31:0] mem [256];

    int total = 0;
    int bad   = 0;

    // Model state
    logic [31:0] m_pc, m_inst, m_p4, m_epc;
    logic        m_valid, m_ack, m_pend, m_prev;

    instruction_fetch_if imem_bus ();
    assign imem_bus.imem_data = mem[imem_bus.imem_addr[9:2]];

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .jr             (jr),
        .jr_target      (jr_target),
        .exception      (exception),
        .irq            (irq),
        .imem           (imem_bus),
        .if_id_inst     (if_id_inst),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .irq_ack        (irq_ack),
        .irq_epc        (irq_epc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        stall = 0; flush = 0; br_taken = 0; jump = 0; jr = 0; exception = 0;
        br_target = 0; jump_target = 0; jr_target = 0;
    endtask

    task automatic model_reset();
        m_pc = 32'h8000_0000; m_inst = 0; m_p4 = 0; m_valid = 0;
        m_ack = 0; m_epc = 0; m_pend = 0; m_prev = 0;
    endtask

    // One clock of the fetch stage, from the rules: trap > irq > jr > jump > branch > hold > sequential.
    task automatic model_step();
        logic [31:0] seq;
        logic        redirect, take, rise;
        seq      = m_pc + 32'd4;
        redirect = exception || jr || jump || br_taken;
        take     = m_pend && (m_pc < 32'h8000_0000) && !redirect && !stall;
        rise     = irq && !m_prev;
        if (flush || exception || take) begin
            m_inst = 32'h0; m_valid = 0; m_p4 = seq;
        end else if (!stall) begin
            m_inst = mem[m_pc[9:2]]; m_valid = 1; m_p4 = seq;
        end
        m_ack = take;
        if (take) m_epc = m_pc;
        if (take)      m_pend = 0;
        else if (rise) m_pend = 1;
        m_prev = irq;
        if (exception)     m_pc = 32'h8000_0008;
        else if (take)     m_pc = 32'h8000_0004;
        else if (jr)       m_pc = jr_target;
        else if (jump)     m_pc = jump_target;
        else if (br_taken) m_pc = br_target;
        else if (!stall)   m_pc = seq;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pc"},    imem_bus.imem_addr, m_pc);
        check({tag, ".inst"},  if_id_inst, m_inst);
        check({tag, ".p4"},    if_id_pc_plus4, m_p4);
        check({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
        check({tag, ".ack"},   {31'b0, irq_ack}, {31'b0, m_ack});
        if (m_ack) check({tag, ".epc"}, irq_epc, m_epc);
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst_n = 0;
        irq = 0;
        idle();
        #1;
        check("rst.pc",    imem_bus.imem_addr, 32'h8000_0000);
        check("rst.inst",  if_id_inst, 32'h0);
        check("rst.p4",    if_id_pc_plus4, 32'h0);
        check("rst.valid", {31'b0, if_id_valid}, 32'h0);
        check("rst.ack",   {31'b0, irq_ack}, 32'h0);
        check("rst.epc",   irq_epc, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic go(input logic [31:0] target);
        idle(); jump = 1; jump_target = target; flush = 1;
        step("go");
        idle();
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom & 32'h7FFF_FFFC;
        if ($urandom_range(3) == 0) t[31] = 1'b1;
        return t;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0810_0003;
        idle();
        irq = 0;
        apply_reset();

        // First fetch after reset
        step("boot");
        check("boot.inst",  if_id_inst, 32'h0810_0003);
        check("boot.p4",    if_id_pc_plus4, 32'h8000_0004);
        check("boot.valid", {31'b0, if_id_valid}, 32'h1);

        // Stall holds PC and IF/ID for two cycles
        go(32'h0040_0010);
        stall = 1;
        step("stall1");
        check("stall1.pc", imem_bus.imem_addr, 32'h0040_0010);
        step("stall2");
        check("stall2.pc", imem_bus.imem_addr, 32'h0040_0010);
        stall = 0;
        step("unstall");
        check("unstall.pc", imem_bus.imem_addr, 32'h0040_0014);

        // Branch with flush and stall together
        br_taken = 1; br_target = 32'h0040_0040; flush = 1; stall = 1;
        step("brflush");
        check("brflush.pc",    imem_bus.imem_addr, 32'h0040_0040);
        check("brflush.inst",  if_id_inst, 32'h0);
        check("brflush.valid", {31'b0, if_id_valid}, 32'h0);
        idle();

        // Interrupt from user mode, then irq held high
        go(32'h0040_001C);
        irq = 1;
        step("irq_edge");
        step("irq_take");
        check("irq_take.ack", {31'b0, irq_ack}, 32'h1);
        check("irq_take.epc", irq_epc, 32'h0040_0020);
        check("irq_take.pc",  imem_bus.imem_addr, 32'h8000_0004);
        for (int i = 0; i < 3; i++) begin
            step("irq_held");
            check("irq_held.ack", {31'b0, irq_ack}, 32'h0);
        end

        // Interrupt deferred while in supervisor mode
        irq = 0;
        step("irq_low");
        go(32'h8000_0090);
        irq = 1;
        step("sup_edge");
        step("sup_wait");
        check("sup_wait.ack", {31'b0, irq_ack}, 32'h0);
        jr = 1; jr_target = 32'h0040_0024; flush = 1;
        step("sup_jr");
        idle();
        step("sup_take");
        check("sup_take.ack", {31'b0, irq_ack}, 32'h1);
        check("sup_take.epc", irq_epc, 32'h0040_0024);

        // Exception beats jump and a pending irq; irq stays pending
        irq = 0;
        step("exc_low");
        irq = 1;
        step("exc_edge");
        exception = 1; jump = 1; jump_target = 32'h0040_0100;
        step("exc");
        check("exc.pc",    imem_bus.imem_addr, 32'h8000_0008);
        check("exc.valid", {31'b0, if_id_valid}, 32'h0);
        idle();
        go(32'h0040_0200);
        step("exc_late");
        check("exc_late.ack", {31'b0, irq_ack}, 32'h1);
        check("exc_late.epc", irq_epc, 32'h0040_0200);

        // PC+4 wraps at the top of the address space
        go(32'hFFFF_FFFC);
        step("wrap");
        check("wrap.pc", imem_bus.imem_addr, 32'h0000_0000);

        // Reset during a stalled pending irq discards the request
        irq = 0;
        step("mid_low");
        go(32'h0040_0300);
        irq = 1;
        stall = 1;
        step("mid_edge");
        step("mid_stall");
        apply_reset();
        for (int i = 0; i < 3; i++) step("post_rst");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) apply_reset();
            stall     = ($urandom_range(3) == 0);
            flush     = ($urandom_range(6) == 0);
            br_taken  = ($urandom_range(9) == 0);
            jump      = ($urandom_range(15) == 0);
            jr        = ($urandom_range(15) == 0);
            exception = ($urandom_range(39) == 0);
            br_target   = rand_target();
            jump_target = rand_target();
            jr_target   = rand_target();
            if ($urandom_range(7) == 0) irq = ~irq;
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
